iot_sequencer: RTL

//  Executes PDP-8 IOT instructions (opcode 6) against NDEV device channels that use the iot_if signal set.

---
 rtl/iot_sequencer.sv | 122 ++++++++++++
 1 files changed

// File: rtl/iot_sequencer.sv
// PDP-8 IOT sequencer: decodes the device select of an opcode-6 instruction and
// walks the IOP1/IOP2/IOP4 phases against one of NDEV device channels.
module iot_sequencer #(
  parameter int               NDEV      = 2,
  parameter logic [6*NDEV-1:0] DEV_CODES = {6'o03, 6'o04},
  parameter logic [NDEV-1:0]   IRQ_MASK  = '1
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start,
  input  logic [11:0]       instr,
  input  logic [11:0]       ac_in,
  output logic              busy,
  output logic              done,
  output logic              skip,
  output logic [11:0]       ac_out,
  output logic              nodev,
  output logic              irq,
  input  logic [NDEV-1:0]   dev_ready,
  output logic [NDEV-1:0]   dev_clear,
  input  logic [NDEV-1:0]   dev_clearacc,
  output logic [7:0]        dev_dataout,
  input  logic [8*NDEV-1:0] dev_datain,
  output logic [NDEV-1:0]   dev_load
);

  localparam int IDX_W = (NDEV > 1) ? $clog2(NDEV) : 1;

  typedef enum logic [2:0] {S_IDLE, S_P1, S_P2, S_P4, S_DONE} state_t;

  state_t           state, state_nxt;
  logic             accept;
  logic             hit_c;
  logic [IDX_W-1:0] idx_c;
  logic [2:0]       iop_q;
  logic             hit_q;
  logic [IDX_W-1:0] idx_q;
  logic [11:0]      ac_q;
  logic             skip_q;
  logic [11:0]      ac_fin;

  // Scan from the top so the lowest matching channel is the one that sticks.
  function automatic logic [IDX_W:0] match_dev(input logic [5:0] dev);
    logic [IDX_W:0] r;
    r = '0;
    for (int i = NDEV - 1; i >= 0; i--) begin
      if (DEV_CODES[6*i +: 6] == dev) r = {1'b1, IDX_W'(i)};
    end
    return r;
  endfunction

  assign {hit_c, idx_c} = match_dev(instr[8:3]);
  assign accept = (state == S_IDLE) && start && (instr[11:9] == 3'o6);
  assign busy   = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (!nrst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    dev_clear = '0;
    dev_load  = '0;
    done      = 1'b0;
    case (state)
      S_IDLE: if (accept) state_nxt = S_P1;
      S_P1:   state_nxt = S_P2;
      S_P2: begin
        state_nxt = S_P4;
        if (iop_q[1] && hit_q) dev_clear[idx_q] = 1'b1;
      end
      S_P4: begin
        state_nxt = S_DONE;
        if (iop_q[2] && hit_q) dev_load[idx_q] = 1'b1;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
        done      = 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Only the low byte takes device data; AC[11:8] passes through.
  always_comb begin
    ac_fin = ac_q;
    if (iop_q[2] && hit_q) ac_fin[7:0] = ac_q[7:0] | dev_datain[8*int'(idx_q) +: 8];
  end

  // Working registers are fully reloaded on accept, so they carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      iop_q  <= instr[2:0];
      hit_q  <= hit_c;
      idx_q  <= idx_c;
      ac_q   <= ac_in;
      skip_q <= 1'b0;
    end
    if (state == S_P1 && iop_q[0] && hit_q && dev_ready[idx_q]) skip_q <= 1'b1;
    if (state == S_P2 && iop_q[1] && hit_q && dev_clearacc[idx_q]) ac_q <= '0;
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      irq         <= 1'b0;
      dev_dataout <= '0;
      skip        <= 1'b0;
      ac_out      <= '0;
      nodev       <= 1'b0;
    end else begin
      irq <= |(dev_ready & IRQ_MASK);
      if (accept) dev_dataout <= ac_in[7:0];
      if (state == S_P4) begin
        skip   <= skip_q;
        ac_out <= ac_fin;
        nodev  <= !hit_q;
      end
    end
  end

endmodule
